// File: rtl/trb_mem_scheduler_pkg.sv
// Shared types and sizing for the trace RAM scheduler.
// The ring-pointer increment helper lives here so every pointer wraps the same way.
package trb_mem_scheduler_pkg;

    localparam int unsigned TRB_WIDTH      = 16;
    localparam int unsigned TRB_DEPTH      = 16;
    localparam int unsigned TRB_ADDR_WIDTH = $clog2(TRB_DEPTH);

    typedef enum logic [1:0] {
        P0LogWr = 2'd0,
        P1LogRd = 2'd1,
        P2IfWr  = 2'd2,
        P3IfRd  = 2'd3
    } sched_phase_t;

    typedef enum logic [1:0] {
        StReset = 2'd0,
        StClear = 2'd1,
        StRun   = 2'd2
    } sched_state_t;

    localparam logic [1:0] MODE_TRACE     = 2'd0;
    localparam logic [1:0] MODE_R_STREAM  = 2'd1;
    localparam logic [1:0] MODE_RW_STREAM = 2'd2;
    localparam logic [1:0] MODE_OTHER     = 2'd3;

    // Increment with one guard bit, then truncate: wraps mod TRB_DEPTH.
    function automatic logic [TRB_ADDR_WIDTH-1:0] ptr_inc(input logic [TRB_ADDR_WIDTH-1:0] p);
        logic [TRB_ADDR_WIDTH:0] sum;
        sum = {1'b0, p} + (TRB_ADDR_WIDTH+1)'(1);
        return sum[TRB_ADDR_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/trb_mem_scheduler_ring_ptr.sv
// Wrapping RAM pointer with increment, load and a configurable reset value.
// Load together with increment lands one past the loaded address.
module trb_ring_ptr
    import trb_mem_scheduler_pkg::*;
#(
    parameter logic [TRB_ADDR_WIDTH-1:0] ResetVal = '0
) (
    input  logic                      CLK_I,
    input  logic                      RST_I,
    input  logic                      INC_I,
    input  logic                      LOAD_I,
    input  logic [TRB_ADDR_WIDTH-1:0] LOAD_VAL_I,
    output logic [TRB_ADDR_WIDTH-1:0] PTR_O
);

    logic [TRB_ADDR_WIDTH-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (LOAD_I) begin
            ptr_d = INC_I ? ptr_inc(LOAD_VAL_I) : LOAD_VAL_I;
        end else if (INC_I) begin
            ptr_d = ptr_inc(ptr_q);
        end
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            ptr_q <= ResetVal;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign PTR_O = ptr_q;

endmodule

// File: rtl/trb_mem_scheduler.sv
// Four-slot TDM scheduler and host pointer guard for the shared single-port trace RAM.
// Define TRB_MEM_SCHED_CLEAR_EN to zero the RAM after reset before entering RUN.
module trb_mem_scheduler
    import trb_mem_scheduler_pkg::*;
(
    input  logic                      CLK_I,
    input  logic                      RST_I,
    input  logic [1:0]                MODE_I,
    input  logic                      TRG_DELAYED_I,
    output logic                      RW_TURN_O,
    output logic                      WRITE_ALLOW_O,
    output logic                      READ_ALLOW_O,
    input  logic                      LOG_WRITE_I,
    input  logic [TRB_ADDR_WIDTH-1:0] LOG_WRITE_PTR_I,
    input  logic [TRB_WIDTH-1:0]      LOG_DATA_I,
    input  logic [TRB_ADDR_WIDTH-1:0] LOG_READ_PTR_I,
    output logic [TRB_WIDTH-1:0]      LOG_DATA_O,
    input  logic                      IF_WRITE_I,
    input  logic [TRB_WIDTH-1:0]      IF_DATA_I,
    output logic                      IF_WRITE_ACK_O,
    input  logic                      IF_READ_I,
    output logic [TRB_WIDTH-1:0]      IF_DATA_O,
    output logic                      IF_READ_ACK_O,
    output logic                      MEM_WE_O,
    output logic [TRB_ADDR_WIDTH-1:0] MEM_ADDR_O,
    output logic [TRB_WIDTH-1:0]      MEM_WDATA_O,
    input  logic [TRB_WIDTH-1:0]      MEM_RDATA_I,
    output logic                      BUSY_O
);

    localparam logic [TRB_ADDR_WIDTH-1:0] RdPtrInit = TRB_ADDR_WIDTH'(TRB_DEPTH / 2 - 1);

    sched_state_t              state_q;
    sched_phase_t              phase_q;
    logic                      trg_q;
    logic                      wr_ack_q, rd_ack_q;
    logic [TRB_WIDTH-1:0]      if_rdata_q;
`ifdef TRB_MEM_SCHED_CLEAR_EN
    logic [TRB_ADDR_WIDTH-1:0] clr_addr_q;
`endif

    logic [TRB_ADDR_WIDTH-1:0] if_wr_ptr, if_rd_ptr, if_rd_addr;
    logic run, rw_mode, trace_mode, trg_rise;
    logic log_wr_ok, log_rd_ok, if_rd_valid, if_wr_go, if_rd_go;

    assign run        = (state_q == StRun);
    assign rw_mode    = (MODE_I == MODE_RW_STREAM);
    assign trace_mode = (MODE_I == MODE_TRACE);
    assign trg_rise   = trace_mode & TRG_DELAYED_I & ~trg_q;

    // Each side must not step onto the slot the other side still owns.
    assign log_wr_ok   = rw_mode ? (ptr_inc(LOG_WRITE_PTR_I) != if_rd_ptr) : 1'b1;
    assign log_rd_ok   = rw_mode ? (LOG_READ_PTR_I != if_wr_ptr) : 1'b1;
    assign if_rd_valid = trace_mode ? TRG_DELAYED_I : (if_rd_ptr != LOG_WRITE_PTR_I);

    // A trigger edge landing in the host read slot reads the freshly loaded oldest word.
    assign if_rd_addr = trg_rise ? LOG_WRITE_PTR_I : if_rd_ptr;

    assign if_wr_go = run & (phase_q == P2IfWr) & IF_WRITE_I
                      & (ptr_inc(if_wr_ptr) != LOG_READ_PTR_I);
    assign if_rd_go = run & (phase_q == P3IfRd) & IF_READ_I & if_rd_valid;

    trb_ring_ptr #(
        .ResetVal ('0)
    ) u_if_wr_ptr (
        .CLK_I      (CLK_I),
        .RST_I      (RST_I),
        .INC_I      (if_wr_go),
        .LOAD_I     (1'b0),
        .LOAD_VAL_I ('0),
        .PTR_O      (if_wr_ptr)
    );

    trb_ring_ptr #(
        .ResetVal (RdPtrInit)
    ) u_if_rd_ptr (
        .CLK_I      (CLK_I),
        .RST_I      (RST_I),
        .INC_I      (if_rd_go),
        .LOAD_I     (run & trg_rise),
        .LOAD_VAL_I (LOG_WRITE_PTR_I),
        .PTR_O      (if_rd_ptr)
    );

    always_comb begin
        RW_TURN_O     = 1'b0;
        WRITE_ALLOW_O = 1'b0;
        READ_ALLOW_O  = 1'b0;
        LOG_DATA_O    = '0;
        MEM_WE_O      = 1'b0;
        MEM_ADDR_O    = '0;
        MEM_WDATA_O   = '0;
`ifdef TRB_MEM_SCHED_CLEAR_EN
        if (state_q == StClear) begin
            MEM_WE_O   = 1'b1;
            MEM_ADDR_O = clr_addr_q;
        end
`endif
        if (run) begin
            unique case (phase_q)
                P0LogWr: begin
                    RW_TURN_O     = 1'b1;
                    WRITE_ALLOW_O = log_wr_ok;
                    MEM_WE_O      = LOG_WRITE_I & log_wr_ok;
                    MEM_ADDR_O    = LOG_WRITE_PTR_I;
                    MEM_WDATA_O   = LOG_DATA_I;
                end
                P1LogRd: begin
                    READ_ALLOW_O = log_rd_ok;
                    MEM_ADDR_O   = LOG_READ_PTR_I;
                    LOG_DATA_O   = MEM_RDATA_I;
                end
                P2IfWr: begin
                    MEM_WE_O    = if_wr_go;
                    MEM_ADDR_O  = if_wr_ptr;
                    MEM_WDATA_O = IF_DATA_I;
                end
                P3IfRd: begin
                    MEM_ADDR_O = if_rd_addr;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q    <= StReset;
            phase_q    <= P0LogWr;
            trg_q      <= 1'b0;
            wr_ack_q   <= 1'b0;
            rd_ack_q   <= 1'b0;
            if_rdata_q <= '0;
`ifdef TRB_MEM_SCHED_CLEAR_EN
            clr_addr_q <= '0;
`endif
        end else begin
            trg_q    <= TRG_DELAYED_I;
            wr_ack_q <= if_wr_go;
            rd_ack_q <= if_rd_go;
            if (if_rd_go) begin
                if_rdata_q <= MEM_RDATA_I;
            end
            unique case (state_q)
                StReset: begin
`ifdef TRB_MEM_SCHED_CLEAR_EN
                    state_q    <= StClear;
                    clr_addr_q <= '0;
`else
                    state_q    <= StRun;
`endif
                    phase_q <= P0LogWr;
                end
                StClear: begin
`ifdef TRB_MEM_SCHED_CLEAR_EN
                    clr_addr_q <= ptr_inc(clr_addr_q);
                    if (&clr_addr_q) begin
                        state_q <= StRun;
                        phase_q <= P0LogWr;
                    end
`else
                    state_q <= StRun;
                    phase_q <= P0LogWr;
`endif
                end
                StRun: begin
                    phase_q <= sched_phase_t'(phase_q + 2'd1);
                end
                default: begin
                    state_q <= StReset;
                end
            endcase
        end
    end

    assign IF_WRITE_ACK_O = wr_ack_q;
    assign IF_READ_ACK_O  = rd_ack_q;
    assign IF_DATA_O      = if_rdata_q;
    assign BUSY_O         = ~run;

endmodule

// File: tb/tb_trb_mem_scheduler.sv
// Directed bench for trb_mem_scheduler with a behavioural async-read RAM.
// Honours TRB_MEM_SCHED_CLEAR_EN when the RAM clear phase is built in.
module tb_trb_mem_scheduler;
    import trb_mem_scheduler_pkg::*;

    logic                      CLK_I = 1'b0;
    logic                      RST_I;
    logic [1:0]                MODE_I;
    logic                      TRG_DELAYED_I;
    logic                      RW_TURN_O, WRITE_ALLOW_O, READ_ALLOW_O;
    logic                      LOG_WRITE_I;
    logic [TRB_ADDR_WIDTH-1:0] LOG_WRITE_PTR_I, LOG_READ_PTR_I;
    logic [TRB_WIDTH-1:0]      LOG_DATA_I, LOG_DATA_O;
    logic                      IF_WRITE_I, IF_WRITE_ACK_O, IF_READ_I, IF_READ_ACK_O;
    logic [TRB_WIDTH-1:0]      IF_DATA_I, IF_DATA_O;
    logic                      MEM_WE_O;
    logic [TRB_ADDR_WIDTH-1:0] MEM_ADDR_O;
    logic [TRB_WIDTH-1:0]      MEM_WDATA_O, MEM_RDATA_I;
    logic                      BUSY_O;

    logic [TRB_WIDTH-1:0] ram [TRB_DEPTH];
    int n_err = 0;
    int n_chk = 0;
    logic [1:0] ph = 2'd0;

    always #5 CLK_I = ~CLK_I;

    trb_mem_scheduler dut (
        .CLK_I           (CLK_I),
        .RST_I           (RST_I),
        .MODE_I          (MODE_I),
        .TRG_DELAYED_I   (TRG_DELAYED_I),
        .RW_TURN_O       (RW_TURN_O),
        .WRITE_ALLOW_O   (WRITE_ALLOW_O),
        .READ_ALLOW_O    (READ_ALLOW_O),
        .LOG_WRITE_I     (LOG_WRITE_I),
        .LOG_WRITE_PTR_I (LOG_WRITE_PTR_I),
        .LOG_DATA_I      (LOG_DATA_I),
        .LOG_READ_PTR_I  (LOG_READ_PTR_I),
        .LOG_DATA_O      (LOG_DATA_O),
        .IF_WRITE_I      (IF_WRITE_I),
        .IF_DATA_I       (IF_DATA_I),
        .IF_WRITE_ACK_O  (IF_WRITE_ACK_O),
        .IF_READ_I       (IF_READ_I),
        .IF_DATA_O       (IF_DATA_O),
        .IF_READ_ACK_O   (IF_READ_ACK_O),
        .MEM_WE_O        (MEM_WE_O),
        .MEM_ADDR_O      (MEM_ADDR_O),
        .MEM_WDATA_O     (MEM_WDATA_O),
        .MEM_RDATA_I     (MEM_RDATA_I),
        .BUSY_O          (BUSY_O)
    );

    initial begin
        for (int i = 0; i < TRB_DEPTH; i++) ram[i] = '0;
    end

    always @(posedge CLK_I) begin
        if (MEM_WE_O) ram[MEM_ADDR_O] <= MEM_WDATA_O;
    end
    assign MEM_RDATA_I = ram[MEM_ADDR_O];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and settle; ph mirrors the expected slot.
    task automatic tick();
        @(posedge CLK_I);
        #2;
        ph = ph + 2'd1;
    endtask

    task automatic goto(input logic [1:0] p);
        for (int i = 0; i < 4 && ph != p; i++) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST_I = 1'b1; MODE_I = MODE_RW_STREAM; TRG_DELAYED_I = 1'b0;
        LOG_WRITE_I = 1'b0; LOG_WRITE_PTR_I = '0; LOG_DATA_I = '0; LOG_READ_PTR_I = '0;
        IF_WRITE_I = 1'b0; IF_DATA_I = '0; IF_READ_I = 1'b0;
        tick(); tick();
        chk("busy_in_reset", BUSY_O, 1);
        chk("rw_turn_in_reset", RW_TURN_O, 0);
        chk("we_in_reset", MEM_WE_O, 0);
        chk("if_data_reset", IF_DATA_O, 0);
        chk("rd_ack_reset", IF_READ_ACK_O, 0);
        chk("wr_ack_reset", IF_WRITE_ACK_O, 0);
        RST_I = 1'b0;
`ifdef TRB_MEM_SCHED_CLEAR_EN
        tick();
        for (int i = 0; i < TRB_DEPTH; i++) begin
            chk("clear_busy", BUSY_O, 1);
            chk("clear_we", MEM_WE_O, 1);
            chk("clear_addr", MEM_ADDR_O, i);
            chk("clear_rw_turn", RW_TURN_O, 0);
            tick();
        end
`else
        tick();
`endif
        ph = 2'd0;
        chk("busy_run", BUSY_O, 0);
        chk("rw_turn_p0", RW_TURN_O, 1);

        // P0: ptr 6 would step onto host read ptr 7
        LOG_WRITE_PTR_I = 4'd6; LOG_WRITE_I = 1'b1; LOG_DATA_I = 16'h00A5; #1;
        chk("wa_blocked", WRITE_ALLOW_O, 0);
        chk("we_blocked", MEM_WE_O, 0);
        LOG_WRITE_PTR_I = 4'd7; #1;
        chk("wa_ok", WRITE_ALLOW_O, 1);
        chk("we_log", MEM_WE_O, 1);
        chk("addr_log", MEM_ADDR_O, 7);
        chk("wdata_log", MEM_WDATA_O, 16'h00A5);
        tick();

        LOG_WRITE_I = 1'b0; LOG_WRITE_PTR_I = 4'd8; LOG_READ_PTR_I = 4'd0; #1;
        chk("rw_turn_p1", RW_TURN_O, 0);
        chk("ra_empty", READ_ALLOW_O, 0);
        LOG_READ_PTR_I = 4'd7; #1;
        chk("ra_ok", READ_ALLOW_O, 1);
        chk("log_rdata", LOG_DATA_O, 16'h00A5);
        LOG_READ_PTR_I = 4'd0; IF_READ_I = 1'b1;
        tick();
        chk("rw_turn_p2", RW_TURN_O, 0);
        chk("log_data_p2", LOG_DATA_O, 0);
        chk("we_p2_idle", MEM_WE_O, 0);
        chk("ra_p2", READ_ALLOW_O, 0);
        tick();
        chk("rw_turn_p3", RW_TURN_O, 0);
        chk("if_rd_addr", MEM_ADDR_O, 7);
        chk("rd_ack_early", IF_READ_ACK_O, 0);
        tick();
        chk("rd_ack", IF_READ_ACK_O, 1);
        chk("if_rdata", IF_DATA_O, 16'h00A5);
        chk("rw_turn_p0b", RW_TURN_O, 1);
        IF_READ_I = 1'b0; LOG_WRITE_PTR_I = 4'd7; #1;
        chk("wa_rd_ptr8", WRITE_ALLOW_O, 0);
        LOG_WRITE_PTR_I = 4'd8; #1;
        chk("wa_ptr8_ok", WRITE_ALLOW_O, 1);
        tick();
        chk("rd_ack_pulse", IF_READ_ACK_O, 0);

        // Host fills 15 words, 16th blocked by Logger read ptr 0
        for (int i = 0; i < 15; i++) begin
            IF_WRITE_I = 1'b1; IF_DATA_I = 16'h0100 + 16'(i);
            goto(2'd2);
            chk("we_host", MEM_WE_O, 1);
            chk("addr_host", MEM_ADDR_O, i);
            tick();
            chk("wr_ack", IF_WRITE_ACK_O, 1);
        end
        IF_DATA_I = 16'h010F;
        goto(2'd2);
        chk("we_full", MEM_WE_O, 0);
        tick();
        chk("wr_ack_full", IF_WRITE_ACK_O, 0);
        LOG_READ_PTR_I = 4'd1;
        goto(2'd2);
        chk("we_unblocked", MEM_WE_O, 1);
        chk("addr_unblocked", MEM_ADDR_O, 15);
        tick();
        chk("wr_ack_unblocked", IF_WRITE_ACK_O, 1);
        IF_WRITE_I = 1'b0;

        // Request withdrawn before its slot leaves no trace
        LOG_READ_PTR_I = 4'd8;
        goto(2'd0);
        IF_WRITE_I = 1'b1;
        tick();
        IF_WRITE_I = 1'b0;
        goto(2'd2);
        chk("we_dropped", MEM_WE_O, 0);
        tick();
        chk("wr_ack_dropped", IF_WRITE_ACK_O, 0);

        // Trace mode: reads wait for trigger, then start at the Logger write ptr
        MODE_I = MODE_TRACE; LOG_WRITE_PTR_I = 4'd3; LOG_READ_PTR_I = 4'd0; IF_READ_I = 1'b1;
        tick();
        chk("rd_ack_no_trg", IF_READ_ACK_O, 0);
        chk("wa_trace", WRITE_ALLOW_O, 1);
        TRG_DELAYED_I = 1'b1;
        tick();
        chk("ra_trace", READ_ALLOW_O, 1);
        for (int k = 0; k < 3; k++) begin
            goto(2'd3);
            chk("trace_rd_addr", MEM_ADDR_O, 3 + k);
            tick();
            chk("trace_rd_ack", IF_READ_ACK_O, 1);
            chk("trace_rdata", IF_DATA_O, 16'h0103 + 16'(k));
            if (k == 2) IF_READ_I = 1'b0;
            goto(2'd1);
            chk("ra_trace_p1", READ_ALLOW_O, 1);
        end

        // Back to rw_stream: host read ptr now 6
        MODE_I = MODE_RW_STREAM;
        goto(2'd0);
        LOG_WRITE_PTR_I = 4'd5; #1;
        chk("wa_rd_ptr6", WRITE_ALLOW_O, 0);
        LOG_WRITE_PTR_I = 4'd9; LOG_WRITE_I = 1'b1; #1;
        chk("we_before_rst", MEM_WE_O, 1);
        RST_I = 1'b1; #1;
        chk("we_mid_rst", MEM_WE_O, 0);
        chk("busy_mid_rst", BUSY_O, 1);
        chk("rw_turn_mid_rst", RW_TURN_O, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
